// File: rtl/aes_pkg.sv
// Shared AES definitions: widths, word type, round constants and word helpers.
package aes_pkg;
    localparam int AES_KEY_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_NWORDS = AES_KEY_W / AES_WORD_W;

    typedef logic [AES_WORD_W-1:0] aes_word_t;

    localparam aes_word_t RCON [1:10] = '{
        32'h01000000, 32'h02000000, 32'h04000000, 32'h08000000, 32'h10000000,
        32'h20000000, 32'h40000000, 32'h80000000, 32'h1b000000, 32'h36000000
    };

    // Byte left-rotate {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box: pure combinational 256-entry lookup.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);
    always_comb begin
        sub = 8'h00;
        case (data)
            8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
            8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
            8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
            8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
            8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
            8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
            8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
            8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
            8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
            8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
            8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
            8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
            8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
            8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
            8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
            8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
            8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
            8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
            8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
            8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
            8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
            8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
            8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
            8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
            8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
            8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
            8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
            8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
            8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
            8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
            8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
            8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
            default: sub = 8'h00;
        endcase
    end
endmodule

// File: rtl/key_expansion_round.sv
// One AES-128 key-schedule round with a registered output (1-cycle latency).
module key_expansion_round
    import aes_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] key_i,
    input  logic [31:0]      rcon_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] key_o
);
    localparam int STAGES = 1;

    generate
        if (WIDTH != AES_KEY_W) begin : g_bad_width
            $error("key_expansion_round: only WIDTH=128 is supported");
        end
    endgenerate

    // w[3] is the most significant word (w0), w[0] the least (w3).
    logic [AES_NWORDS-1:0][AES_WORD_W-1:0] w, nw;
    logic [3:0][7:0] rot, sub;
    aes_word_t       temp;
    logic [STAGES:0] vld_pipe;

    assign w   = key_i[AES_KEY_W-1:0];
    assign rot = rot_word(w[0]);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (.data(rot[b]), .sub(sub[b]));
    end

    assign temp  = sub ^ rcon_i;
    assign nw[3] = w[3] ^ temp;
    assign nw[2] = nw[3] ^ w[2];
    assign nw[1] = nw[2] ^ w[1];
    assign nw[0] = nw[1] ^ w[0];

    assign vld_pipe[0] = valid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe[STAGES:1] <= '0;
            key_o              <= '0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            // Capture only qualified inputs so an idle bus never disturbs the held key.
            if (valid_i)
                key_o <= WIDTH'(nw);
        end
    end

    assign valid_o = vld_pipe[STAGES];
endmodule

// File: tb/tb_key_expansion_round.sv
// Scoreboard bench for key_expansion_round using FIPS-197 key-schedule vectors.
module tb_key_expansion_round;
    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [31:0]  rcon_i = '0;
    logic         valid_o;
    logic [127:0] key_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K2   = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K9   = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KZ   = 128'h62636363626363636263636362636363;

    key_expansion_round #(.WIDTH(128)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i),
        .key_i(key_i), .rcon_i(rcon_i), .valid_o(valid_o), .key_o(key_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] k, input logic [31:0] rc, input logic [127:0] exp);
        @(posedge clk_i); #1;
        valid_i = 1'b1;
        key_i   = k;
        rcon_i  = rc;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (n - 1) @(posedge clk_i);
    endtask

    // Monitor: every presented result must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_n_i && valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got key %h with no pending expectation", key_o);
                end else begin
                    check("scoreboard_key", key_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset from time zero, including across clock edges.
        #12;
        check("reset_key", key_o, '0);
        check("reset_valid", {127'b0, valid_o}, '0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;

        send(K0, 32'h01000000, K1);
        send(K1, 32'h02000000, K2);
        send(K9, 32'h36000000, K10);
        send('0, 32'h01000000, KZ);

        // Drop valid with a different key: output must hold, valid must fall.
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        key_i   = K9;
        rcon_i  = 32'h1b000000;
        @(posedge clk_i); #1;
        check("hold_key", key_o, KZ);
        check("hold_valid", {127'b0, valid_o}, '0);
        @(posedge clk_i); #1;
        check("hold_key_2", key_o, KZ);

        // Asynchronous reset mid-cycle while valid_i is high.
        valid_i = 1'b1;
        key_i   = K0;
        rcon_i  = 32'h01000000;
        #2;
        rst_n_i = 1'b0;
        #1;
        check("async_reset_key", key_o, '0);
        check("async_reset_valid", {127'b0, valid_o}, '0);
        @(posedge clk_i); #1;
        check("held_reset_key", key_o, '0);
        check("held_reset_valid", {127'b0, valid_o}, '0);
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        #2;
        rst_n_i = 1'b1;

        send(K0, 32'h01000000, K1);
        send(K9, 32'h36000000, K10);
        idle(4);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end
endmodule
